ov5640_dvp_tx: RTL and testbench
================================

# ov5640_dvp_tx

Sensor-side DVP transmitter that emulates an OV5640 raw 8-bit parallel output: frame sync, line-valid strobe and a synthetic Bayer-mosaic test image. It drives the capture path's `in_data`/`in_vsync`/`in_hsync` inputs during simulation and board bring-up, so the line buffer, operator and CFA chain can be exercised without a physical camera. The video timing is fully parameterised, and pattern selection is latched per frame.

## Interface
Parameters:
- VIDEO_WIDTH, 1280: active pixels per line
- VIDEO_HEIGHT, 720: active lines per frame
- VIDEO_DATA_WIDTH, 8: pixel width W, minimum 3
- H_BLANK, 64: blank cycles after each line's active pixels
- V_SYNC, 2: lines with vsync high
- V_BACK, 4: blank lines between vsync falling and the first active line
- V_FRONT, 2: blank lines after the last active line

Ports:
- clk  in  1  pixel clock; all logic runs on the rising edge
- rst  in  1  asynchronous, active-low reset
- in_enable  in  1  run request; sampled only at frame boundaries
- in_pattern  in  2  0 = ramp, 1 = vertical bars, 2 = flat mid-grey, 3 = frame counter
- out_data  out  W  raw Bayer pixel
- out_vsync  out  1  frame sync, active high
- out_hsync  out  1  line valid (HREF), high during active pixels only
- out_frame_start  out  1  one-cycle pulse on the first cycle of vsync

## Operation
- Line length L = VIDEO_WIDTH + H_BLANK cycles. Every sync, blank and active line lasts exactly L cycles.
- Counters:
  - `h_cnt`: 0..L-1
  - `v_cnt`: line index within the current state
  - `frame_cnt`: W bits, wraps modulo 2^W
- States:
  - IDLE: all outputs 0.
  - VSYNC: V_SYNC lines, `out_vsync` = 1.
  - VBACK: V_BACK lines.
  - ACTIVE: VIDEO_HEIGHT lines. `out_hsync` = 1 for `h_cnt` < VIDEO_WIDTH, otherwise 0.
  - VFRONT: V_FRONT lines.
- Transitions:
  - IDLE→VSYNC when `in_enable` = 1.
  - VSYNC→VBACK→ACTIVE→VFRONT on each state's last cycle.
  - VFRONT→VSYNC if `in_enable` = 1 on VFRONT's last cycle; otherwise VFRONT→IDLE.
  - A state with a zero line count is skipped.
- Deassertion of `in_enable` mid-frame has no effect until the frame completes. No partial frames are produced.
- `in_pattern` is latched on entry to VSYNC and held for the whole frame.
- `frame_cnt` increments on the VFRONT→VSYNC or VFRONT→IDLE transition.
- Pixel value at active column x, active row y (all arithmetic truncated to W bits):
  - Ramp: x + y + `frame_cnt`.
  - Bars: `(x * 8 / VIDEO_WIDTH) << (W-3)`, giving eight equal bars of 0, 32, …, 224 for W = 8.
  - Flat: 2^(W-1).
  - Frame counter: `frame_cnt`.
- `out_data` = 0 whenever `out_hsync` = 0.

## Timing
- All outputs are registered. Reset value of every output is 0, and the FSM resets to IDLE with all counters at 0.
- After rst deasserts with `in_enable` = 1: `out_vsync` and `out_frame_start` rise on the second rising edge (one cycle to register the IDLE→VSYNC decision, one for the output register).
- `out_frame_start` is a single-cycle pulse coincident with the first cycle of `out_vsync` = 1.
- `out_hsync` rises exactly (V_SYNC + V_BACK)·L cycles after `out_vsync` rises.
- `out_data` is valid in the same cycle as `out_hsync`, with zero pipeline skew between them.
- Frame period = (V_SYNC + V_BACK + VIDEO_HEIGHT + V_FRONT)·L cycles, with no gap between back-to-back frames.
- Reset asserted mid-frame: outputs clear asynchronously in the same cycle. The block restarts from IDLE, and the frame in progress is lost.

## Structure
- Shared package/header holds:
  - state encodings IDLE, VSYNC, VBACK, ACTIVE, VFRONT;
  - pattern codes PAT_RAMP = 0, PAT_BARS = 1, PAT_FLAT = 2, PAT_FCNT = 3.
- One sub-module, `dvp_pattern_gen`: combinational pixel function of (x, y, `frame_cnt`, latched pattern), returning W bits.
- Top level holds the FSM, counters and output registers.

## Test plan
Common parameters: VIDEO_WIDTH = 8, VIDEO_HEIGHT = 4, H_BLANK = 4, V_SYNC = 1, V_BACK = 1, V_FRONT = 1. This gives L = 12 and a frame of 84 cycles.

- Reset release with `in_enable` = 1, `in_pattern` = 0 → `out_vsync` high for 12 cycles; first `out_hsync` rises 24 cycles after `out_vsync` rises; frame 0 row 0 data reads 0..7; row 3 reads 3..10.
- `in_pattern` = 1 → each active line reads 0, 32, 64, …, 224; `out_data` = 0 during all 4 blank cycles per line.
- Continuous run for 3 frames with `in_pattern` = 3 → every active pixel of frame n equals n; `out_frame_start` pulses exactly at cycles 0, 84 and 168 after the first vsync.
- `in_enable` dropped at active row 1 → the frame completes all 84 cycles, then all outputs stay 0. Re-assert → new vsync, with `frame_cnt` continuing at 1.
- `in_pattern` changed mid-frame from 2 to 0 → the current frame stays at 128 throughout; the next frame is a ramp.
- rst asserted during active row 2 → all outputs 0 in the same cycle. After release, a full frame with correct vsync→hsync spacing of 24 cycles.

Source files
------------

// File: rtl/ov5640_dvp_tx_pkg.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_tx_pkg
//   Shared types for the OV5640-style DVP transmitter: the frame FSM state
//   encoding and the test-pattern selector codes.
// ---------------------------------------------------------------------------
package ov5640_dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        VFRONT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PAT_RAMP = 2'd0,
        PAT_BARS = 2'd1,
        PAT_FLAT = 2'd2,
        PAT_FCNT = 2'd3
    } pattern_t;

    // Number of equal-width vertical bars in the bars pattern; the bar index
    // occupies the top three bits of the pixel.
    localparam int BAR_COUNT = 8;

endpackage

// File: rtl/ov5640_dvp_tx_pattern_gen.sv
// ---------------------------------------------------------------------------
// dvp_pattern_gen
//   Combinational synthetic-image generator. Produces one raw Bayer pixel
//   from the active column/row, the frame counter and the pattern latched
//   for the current frame. All arithmetic is truncated to DATA_WIDTH bits.
//
//   x, y       active column / row
//   frame_cnt  frame counter (DATA_WIDTH bits)
//   pattern    selected test pattern
//   pixel      generated pixel value
// ---------------------------------------------------------------------------
module dvp_pattern_gen
    import ov5640_dvp_tx_pkg::*;
#(
    parameter int VIDEO_WIDTH = 1280,
    parameter int DATA_WIDTH  = 8,
    parameter int XW          = 11,
    parameter int YW          = 10
) (
    input  logic [XW-1:0]         x,
    input  logic [YW-1:0]         y,
    input  logic [DATA_WIDTH-1:0] frame_cnt,
    input  pattern_t              pattern,
    output logic [DATA_WIDTH-1:0] pixel
);

    logic [31:0] bar_idx;

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    always_comb begin
        pixel   = '0;
        bar_idx = (32'(x) * 32'(BAR_COUNT)) / 32'(VIDEO_WIDTH);
        case (pattern)
            PAT_RAMP: pixel = DATA_WIDTH'(x) + DATA_WIDTH'(y) + frame_cnt;
            PAT_BARS: pixel = DATA_WIDTH'(bar_idx << (DATA_WIDTH - 3));
            PAT_FLAT: pixel = DATA_WIDTH'(1) << (DATA_WIDTH - 1);
            PAT_FCNT: pixel = frame_cnt;
            default:  pixel = '0;
        endcase
    end

endmodule

// File: rtl/ov5640_dvp_tx.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_tx
//   Sensor-side DVP transmitter emulating an OV5640 raw 8-bit parallel
//   output. Generates vsync / line-valid timing and a synthetic Bayer image.
//
//   clk              pixel clock, rising edge
//   rst              asynchronous, active-low reset
//   in_enable        run request, sampled only at frame boundaries
//   in_pattern       0 ramp, 1 vertical bars, 2 flat grey, 3 frame counter
//   out_data         raw pixel, 0 whenever out_hsync is low
//   out_vsync        frame sync, active high
//   out_hsync        line valid (HREF), high during active pixels only
//   out_frame_start  one-cycle pulse on the first vsync cycle
// ---------------------------------------------------------------------------
module ov5640_dvp_tx
    import ov5640_dvp_tx_pkg::*;
#(
    parameter int VIDEO_WIDTH      = 1280,
    parameter int VIDEO_HEIGHT     = 720,
    parameter int VIDEO_DATA_WIDTH = 8,
    parameter int H_BLANK          = 64,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 4,
    parameter int V_FRONT          = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_enable,
    input  logic [1:0]                  in_pattern,
    output logic [VIDEO_DATA_WIDTH-1:0] out_data,
    output logic                        out_vsync,
    output logic                        out_hsync,
    output logic                        out_frame_start
);

    localparam int W     = VIDEO_DATA_WIDTH;
    localparam int L     = VIDEO_WIDTH + H_BLANK;
    localparam int HCW   = (L > 1) ? $clog2(L) : 1;
    localparam int V_M1  = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_M2  = (VIDEO_HEIGHT > V_FRONT) ? VIDEO_HEIGHT : V_FRONT;
    localparam int V_MAX = (V_M1 > V_M2) ? V_M1 : V_M2;
    localparam int VCW   = (V_MAX > 0) ? $clog2(V_MAX + 1) : 1;

    localparam logic [HCW-1:0] H_LAST = HCW'(L - 1);

    state_t           state_q, state_d;
    logic [HCW-1:0]   h_cnt_q, h_cnt_d;
    logic [VCW-1:0]   v_cnt_q, v_cnt_d;
    logic [W-1:0]     frame_cnt_q, frame_cnt_d;
    pattern_t         pattern_q, pattern_d;
    logic [W-1:0]     data_q, data_d;
    logic             vsync_q, vsync_d;
    logic             hsync_q, hsync_d;
    logic             fs_q, fs_d;

    logic [W-1:0]     pixel;
    logic             state_last;
    logic             advance;
    state_t           nxt;
    logic             go;
    logic             wrap;
    logic             enter;

    function automatic logic [VCW-1:0] state_lines(input state_t s);
        case (s)
            VSYNC:   return VCW'(V_SYNC);
            VBACK:   return VCW'(V_BACK);
            ACTIVE:  return VCW'(VIDEO_HEIGHT);
            VFRONT:  return VCW'(V_FRONT);
            default: return '0;
        endcase
    endfunction

    dvp_pattern_gen #(
        .VIDEO_WIDTH (VIDEO_WIDTH),
        .DATA_WIDTH  (W),
        .XW          (HCW),
        .YW          (VCW)
    ) u_pattern_gen (
        .x         (h_cnt_q),
        .y         (v_cnt_q),
        .frame_cnt (frame_cnt_q),
        .pattern   (pattern_q),
        .pixel     (pixel)
    );

    // Next-state and counter logic.
    always_comb begin
        state_d     = state_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_cnt_d = frame_cnt_q;
        pattern_d   = pattern_q;
        nxt         = state_q;
        go          = 1'b1;
        wrap        = 1'b0;
        enter       = 1'b0;

        state_last = (h_cnt_q == H_LAST) &&
                     (v_cnt_q == state_lines(state_q) - 1'b1);
        advance    = (state_q == IDLE) ? in_enable : state_last;

        if (state_q != IDLE) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        if (advance) begin
            // Walk the state chain, hopping over any state with zero lines.
            // Bounded by the number of frame states so it always unrolls.
            for (int i = 0; i < 5; i++) begin
                if (go) begin
                    case (nxt)
                        IDLE, VFRONT: begin
                            if (nxt == VFRONT) wrap = 1'b1;
                            if (in_enable) begin
                                nxt   = VSYNC;
                                enter = 1'b1;
                            end else begin
                                nxt = IDLE;
                            end
                        end
                        VSYNC:   nxt = VBACK;
                        VBACK:   nxt = ACTIVE;
                        ACTIVE:  nxt = VFRONT;
                        default: nxt = IDLE;
                    endcase
                    go = (nxt != IDLE) && (state_lines(nxt) == '0);
                end
            end
            state_d = nxt;
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (wrap)  frame_cnt_d = frame_cnt_q + 1'b1;
            if (enter) pattern_d   = pattern_t'(in_pattern);
        end
    end

    // Output decode: computed from the current state/counters and registered,
    // so data and hsync leave on the same edge with no skew.
    always_comb begin
        vsync_d = (state_q == VSYNC);
        fs_d    = (state_q == VSYNC) && (h_cnt_q == '0) && (v_cnt_q == '0);
        hsync_d = (state_q == ACTIVE) && (32'(h_cnt_q) < 32'(VIDEO_WIDTH));
        data_d  = hsync_d ? pixel : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            frame_cnt_q <= '0;
            pattern_q   <= PAT_RAMP;
            data_q      <= '0;
            vsync_q     <= 1'b0;
            hsync_q     <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            pattern_q   <= pattern_d;
            data_q      <= data_d;
            vsync_q     <= vsync_d;
            hsync_q     <= hsync_d;
            fs_q        <= fs_d;
        end
    end

    assign out_data        = data_q;
    assign out_vsync       = vsync_q;
    assign out_hsync       = hsync_q;
    assign out_frame_start = fs_q;

endmodule

// File: tb/tb_ov5640_dvp_tx.sv
// ---------------------------------------------------------------------------
// tb_ov5640_dvp_tx
//   Self-checking bench for ov5640_dvp_tx with an 8x4 active image, 4 blank
//   cycles per line and single sync/back/front lines (L = 12, frame = 84).
//   Frames are captured cycle by cycle starting at out_frame_start, then
//   checked for timing and against a table of hand-computed pixel rows.
// ---------------------------------------------------------------------------
module tb_ov5640_dvp_tx;

    localparam int WIDTH   = 8;
    localparam int HEIGHT  = 4;
    localparam int HBLANK  = 4;
    localparam int LINE    = WIDTH + HBLANK;
    localparam int FRAME   = LINE * (1 + 1 + HEIGHT + 1);
    localparam int NCAP    = 10;
    localparam int ACT_OFS = 2 * LINE;

    logic       clk;
    logic       rst;
    logic       in_enable;
    logic [1:0] in_pattern;
    logic [7:0] out_data;
    logic       out_vsync;
    logic       out_hsync;
    logic       out_frame_start;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] cap_data [NCAP][FRAME];
    logic       cap_vs   [NCAP][FRAME];
    logic       cap_hs   [NCAP][FRAME];
    logic       cap_fs   [NCAP][FRAME];

    typedef struct {
        string           name;
        int              cap;
        int              row;
        logic [7:0][7:0] exp;   // exp[c] is the pixel at column c
    } vec_t;

    vec_t vecs [15];

    ov5640_dvp_tx #(
        .VIDEO_WIDTH      (WIDTH),
        .VIDEO_HEIGHT     (HEIGHT),
        .VIDEO_DATA_WIDTH (8),
        .H_BLANK          (HBLANK),
        .V_SYNC           (1),
        .V_BACK           (1),
        .V_FRONT          (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_enable       (in_enable),
        .in_pattern      (in_pattern),
        .out_data        (out_data),
        .out_vsync       (out_vsync),
        .out_hsync       (out_hsync),
        .out_frame_start (out_frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        else
            pass_cnt++;
    endtask

    function automatic vec_t mk(input string n, input int c, input int r,
                                input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3,
                                input logic [7:0] e4, input logic [7:0] e5,
                                input logic [7:0] e6, input logic [7:0] e7);
        vec_t v;
        v.name = n;
        v.cap  = c;
        v.row  = r;
        v.exp  = {e7, e6, e5, e4, e3, e2, e1, e0};
        return v;
    endfunction

    task automatic do_reset(input logic [1:0] pat, input logic en);
        @(negedge clk);
        rst        = 1'b0;
        in_pattern = pat;
        in_enable  = en;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits (bounded) for the frame-start pulse; reports the negedges waited.
    task automatic wait_fs(input string name, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!out_frame_start && waited < 300);
        check({name, "_fs_seen"}, out_frame_start, 1);
    endtask

    task automatic capture(input int id, input int chg_idx, input logic chg_en,
                           input logic [1:0] chg_pat, output int waited);
        wait_fs($sformatf("cap%0d", id), waited);
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            cap_data[id][i] = out_data;
            cap_vs[id][i]   = out_vsync;
            cap_hs[id][i]   = out_hsync;
            cap_fs[id][i]   = out_frame_start;
            if (i == chg_idx) begin
                in_enable  = chg_en;
                in_pattern = chg_pat;
            end
        end
    endtask

    task automatic check_timing(input int id);
        int vs_n, hs_n, fs_n, blank_nz, first_hs;
        vs_n = 0; hs_n = 0; fs_n = 0; blank_nz = 0; first_hs = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (cap_vs[id][i]) vs_n++;
            if (cap_fs[id][i]) fs_n++;
            if (cap_hs[id][i]) begin
                hs_n++;
                if (first_hs < 0) first_hs = i;
            end else if (cap_data[id][i] != 8'd0) begin
                blank_nz++;
            end
        end
        check($sformatf("cap%0d_vsync_cycles", id), vs_n, LINE);
        check($sformatf("cap%0d_vsync_to_hsync", id), first_hs, ACT_OFS);
        check($sformatf("cap%0d_hsync_cycles", id), hs_n, WIDTH * HEIGHT);
        check($sformatf("cap%0d_fs_pulses", id), fs_n, 1);
        check($sformatf("cap%0d_blank_data_nonzero", id), blank_nz, 0);
    endtask

    initial begin
        int w;
        int idle_nz;

        vecs[0]  = mk("ramp_f0_r0",   0, 0,   0,  1,  2,  3,   4,   5,   6,   7);
        vecs[1]  = mk("ramp_f0_r3",   0, 3,   3,  4,  5,  6,   7,   8,   9,  10);
        vecs[2]  = mk("bars_r0",      1, 0,   0, 32, 64, 96, 128, 160, 192, 224);
        vecs[3]  = mk("bars_r3",      1, 3,   0, 32, 64, 96, 128, 160, 192, 224);
        vecs[4]  = mk("fcnt_f0_r0",   2, 0,   0,  0,  0,  0,   0,   0,   0,   0);
        vecs[5]  = mk("fcnt_f1_r1",   3, 1,   1,  1,  1,  1,   1,   1,   1,   1);
        vecs[6]  = mk("fcnt_f2_r3",   4, 3,   2,  2,  2,  2,   2,   2,   2,   2);
        vecs[7]  = mk("drop_f0_r3",   5, 3,   0,  0,  0,  0,   0,   0,   0,   0);
        vecs[8]  = mk("resume_f1_r0", 6, 0,   1,  1,  1,  1,   1,   1,   1,   1);
        vecs[9]  = mk("flat_r0",      7, 0, 128,128,128,128, 128, 128, 128, 128);
        vecs[10] = mk("flat_r3",      7, 3, 128,128,128,128, 128, 128, 128, 128);
        vecs[11] = mk("ramp_f1_r0",   8, 0,   1,  2,  3,  4,   5,   6,   7,   8);
        vecs[12] = mk("ramp_f1_r2",   8, 2,   3,  4,  5,  6,   7,   8,   9,  10);
        vecs[13] = mk("rst_f0_r0",    9, 0,   0,  1,  2,  3,   4,   5,   6,   7);
        vecs[14] = mk("rst_f0_r1",    9, 1,   1,  2,  3,  4,   5,   6,   7,   8);

        rst        = 1'b0;
        in_enable  = 1'b0;
        in_pattern = 2'd0;
        #12;
        check("reset_data",  out_data, 0);
        check("reset_vsync", out_vsync, 0);
        check("reset_hsync", out_hsync, 0);
        check("reset_fs",    out_frame_start, 0);

        // Ramp from reset release: vsync appears on the second edge.
        do_reset(2'd0, 1'b1);
        capture(0, -1, 1'b1, 2'd0, w);
        check("ramp_release_latency", w, 2);

        // Vertical bars.
        do_reset(2'd1, 1'b1);
        capture(1, -1, 1'b1, 2'd1, w);

        // Three back-to-back frame-counter frames: starts at 0, 84, 168.
        do_reset(2'd3, 1'b1);
        capture(2, -1, 1'b1, 2'd3, w);
        capture(3, -1, 1'b1, 2'd3, w);
        check("fs_at_84", w, 1);
        capture(4, -1, 1'b1, 2'd3, w);
        check("fs_at_168", w, 1);

        // Enable dropped at active row 1: frame completes, then silence.
        do_reset(2'd3, 1'b1);
        capture(5, ACT_OFS + LINE, 1'b0, 2'd3, w);
        idle_nz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_data != 8'd0 || out_vsync || out_hsync || out_frame_start)
                idle_nz++;
        end
        check("idle_after_drop", idle_nz, 0);
        in_enable = 1'b1;
        capture(6, -1, 1'b1, 2'd3, w);
        check("resume_latency", w, 2);

        // Pattern switched mid-frame from flat to ramp.
        do_reset(2'd2, 1'b1);
        capture(7, 40, 1'b1, 2'd0, w);
        capture(8, -1, 1'b1, 2'd0, w);
        check("ramp_follows_flat", w, 1);

        // Reset asserted during active row 2 column 3.
        do_reset(2'd0, 1'b1);
        wait_fs("pre_rst", w);
        repeat (ACT_OFS + 2 * LINE + 3) @(negedge clk);
        check("pre_rst_hsync", out_hsync, 1);
        check("pre_rst_data",  out_data, 5);
        #2 rst = 1'b0;
        #1;
        check("async_rst_data",  out_data, 0);
        check("async_rst_vsync", out_vsync, 0);
        check("async_rst_hsync", out_hsync, 0);
        check("async_rst_fs",    out_frame_start, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        capture(9, -1, 1'b1, 2'd0, w);
        check("post_rst_latency", w, 2);

        for (int c = 0; c < NCAP; c++) check_timing(c);

        foreach (vecs[v]) begin
            for (int col = 0; col < WIDTH; col++) begin
                check($sformatf("%s_c%0d", vecs[v].name, col),
                      cap_data[vecs[v].cap][ACT_OFS + vecs[v].row * LINE + col],
                      vecs[v].exp[col]);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
